// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain head driver: serialises valid/ready bitstream words MSB-first into exactly CHAIN_LEN ccff bits.
// Optional serial CRC-8 check of the shifted bits is enabled with `define CCFF_LOADER_CRC_EN.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done
`ifdef CCFF_LOADER_CRC_EN
    ,
    input  logic [7:0]        crc_expected,
    output logic              crc_err
`endif
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] CHAIN_LEN_C = CW'(CHAIN_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]     left_q, left_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic              head_q, head_d;
    logic              en_q, en_d;
    logic [CW-1:0]     remaining;
    logic [WW-1:0]     word_len;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        left_d    = left_q;
        sr_d      = sr_q;
        head_d    = 1'b0;
        en_d      = 1'b0;
        remaining = CHAIN_LEN_C - bit_cnt_q;
        // The final word may carry fewer useful bits than WORD_W.
        word_len  = (int'(remaining) >= WORD_W) ? WW'(WORD_W) : WW'(remaining);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = LOAD;
                    bit_cnt_d = '0;
                end
            end
            LOAD: begin
                if (bs_valid) begin
                    head_d    = bs_data[WORD_W-1];
                    en_d      = 1'b1;
                    sr_d      = bs_data << 1;
                    left_d    = word_len - WW'(1);
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (left_q != '0) begin
                    head_d    = sr_q[WORD_W-1];
                    en_d      = 1'b1;
                    sr_d      = sr_q << 1;
                    left_d    = left_q - WW'(1);
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end else begin
                    state_d = (bit_cnt_q < CHAIN_LEN_C) ? LOAD : DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            head_d  = 1'b0;
            en_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the shift register is reset too so
    // a reset mid-load never leaves stale word bits behind.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            left_q    <= '0;
            sr_q      <= '0;
            head_q    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            left_q    <= left_d;
            sr_q      <= sr_d;
            head_q    <= head_d;
            en_q      <= en_d;
        end
    end

    assign bs_ready      = (state_q == LOAD);
    assign ccff_head     = head_q;
    assign ccff_shift_en = en_q;
    assign busy          = (state_q == LOAD) || (state_q == SHIFT);
    assign done          = (state_q == DONE);

`ifdef CCFF_LOADER_CRC_EN
    logic [7:0] crc_q, crc_next;
    logic       start_go;

    assign start_go = start && !abort && ((state_q == IDLE) || (state_q == DONE));

    // Serial CRC-8, poly 0x07, MSB-first over every bit presented with shift enable.
    always_comb begin
        crc_next = crc_q;
        if (en_q) begin
            crc_next = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ head_q) ? 8'h07 : 8'h00);
        end
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            crc_q   <= 8'h00;
            crc_err <= 1'b0;
        end else begin
            crc_q <= start_go ? 8'h00 : crc_next;
            if (start_go || abort) begin
                crc_err <= 1'b0;
            end else if (state_q == SHIFT && state_d == DONE) begin
                crc_err <= (crc_next != crc_expected);
            end
        end
    end
`endif

endmodule
